// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// segment patterns, FSM encoding and the double-dabble step helper.
package seven_segment_scan_controller_pkg;

   localparam int unsigned BIN_W    = 7;
   localparam int unsigned BCD_W    = 8;
   localparam int unsigned SEG_W    = 7;
   localparam int unsigned DIGITS   = 4;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned DD_STEPS = 7;
   localparam int unsigned STEP_W   = 3;

   localparam logic [BIN_W-1:0] MAX_VALUE = BIN_W'(99);

   // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] whole_tens;
      logic [3:0] whole_ones;
      logic [3:0] frac_tens;
      logic [3:0] frac_ones;
      logic       sign;
      logic       clamped;
   } display_t;

   // Double-dabble working register: BCD accumulator above the binary shift-out
   typedef struct packed {
      logic [BCD_W-1:0] bcd;
      logic [BIN_W-1:0] bin;
   } dd_t;

   function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
      return (v > MAX_VALUE) ? MAX_VALUE : v;
   endfunction

   function automatic dd_t dd_step(input dd_t s);
      dd_t a;
      a = s;
      if (a.bcd[3:0] >= 4'd5) a.bcd[3:0] = a.bcd[3:0] + 4'd3;
      if (a.bcd[7:4] >= 4'd5) a.bcd[7:4] = a.bcd[7:4] + 4'd3;
      return {a.bcd[BCD_W-2:0], a.bin, 1'b0};
   endfunction

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Result-path / display-pin bundle for the seven-segment scan controller.
interface seven_segment_scan_controller_if;
   import seven_segment_scan_controller_pkg::*;

   logic                load;
   logic [BIN_W-1:0]    whole_number;
   logic [BIN_W-1:0]    fraction_number;
   logic                sign;
   logic                blank;
   logic [DIGITS-1:0]   anode;
   logic [SEG_W-1:0]    cathode;
   logic                dp;
   logic                busy;
   logic                clamped;

   modport master (
      output load, whole_number, fraction_number, sign, blank,
      input  anode, cathode, dp, busy, clamped
   );

   modport slave (
      input  load, whole_number, fraction_number, sign, blank,
      output anode, cathode, dp, busy, clamped
   );

endinterface

// File: rtl/seven_segment_digit_decoder.sv
// BCD digit to active-low seven-segment pattern, with a forced-blank input.
module seven_segment_digit_decoder
   import seven_segment_scan_controller_pkg::*;
(
   input  logic [3:0]       bcd,
   input  logic             blank,
   output logic [SEG_W-1:0] segments_c
);

   always_comb begin
      segments_c = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    segments_c = SEG_0;
            4'd1:    segments_c = SEG_1;
            4'd2:    segments_c = SEG_2;
            4'd3:    segments_c = SEG_3;
            4'd4:    segments_c = SEG_4;
            4'd5:    segments_c = SEG_5;
            4'd6:    segments_c = SEG_6;
            4'd7:    segments_c = SEG_7;
            4'd8:    segments_c = SEG_8;
            4'd9:    segments_c = SEG_9;
            default: segments_c = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Converts a signed fixed-point result to BCD over several cycles and
// time-multiplexes the four digits onto the shared anode/cathode pins.
module seven_segment_scan_controller
   import seven_segment_scan_controller_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                             clock_100Mhz,
   input  logic                             reset,
   seven_segment_scan_controller_if.slave   disp
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_t              state;
   logic [STEP_W-1:0]   step_cnt;
   dd_t                 whole_dd;
   dd_t                 frac_dd;
   logic                sign_q;
   logic                clamp_pend;
   logic                busy_q;
   display_t            disp_q;

   logic [CNT_W-1:0]    refresh_cnt;
   logic [IDX_W-1:0]    digit_idx;

   logic [3:0]          digit_bcd_c;
   logic                digit_blank_c;
   logic                dp_c;
   logic [SEG_W-1:0]    segments_c;

   // Conversion FSM; the display registers only move in COMMIT
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         state      <= IDLE;
         step_cnt   <= '0;
         whole_dd   <= '0;
         frac_dd    <= '0;
         sign_q     <= 1'b0;
         clamp_pend <= 1'b0;
         busy_q     <= 1'b0;
         disp_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (disp.load) begin
                  whole_dd   <= '{bcd: '0, bin: saturate(disp.whole_number)};
                  frac_dd    <= '{bcd: '0, bin: saturate(disp.fraction_number)};
                  clamp_pend <= (disp.whole_number > MAX_VALUE) ||
                                (disp.fraction_number > MAX_VALUE);
                  sign_q     <= disp.sign;
                  step_cnt   <= '0;
                  busy_q     <= 1'b1;
                  state      <= CONVERT;
               end
            end
            CONVERT: begin
               whole_dd <= dd_step(whole_dd);
               frac_dd  <= dd_step(frac_dd);
               step_cnt <= step_cnt + STEP_W'(1);
               if (step_cnt == STEP_W'(DD_STEPS - 1)) state <= COMMIT;
            end
            COMMIT: begin
               disp_q <= '{whole_tens: whole_dd.bcd[7:4],
                           whole_ones: whole_dd.bcd[3:0],
                           frac_tens:  frac_dd.bcd[7:4],
                           frac_ones:  frac_dd.bcd[3:0],
                           sign:       sign_q,
                           clamped:    clamp_pend};
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Free-running digit scan, independent of the FSM and of blank
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + IDX_W'(1);
      end else begin
         refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
   end

   // Digit select: index 2 carries the decimal point, index 3 the sign
   always_comb begin
      digit_bcd_c   = disp_q.frac_ones;
      digit_blank_c = 1'b0;
      dp_c          = 1'b1;
      case (digit_idx)
         2'd1: digit_bcd_c = disp_q.frac_tens;
         2'd2: begin
            digit_bcd_c = disp_q.whole_ones;
            dp_c        = 1'b0;
         end
         2'd3: begin
            digit_bcd_c   = disp_q.whole_tens;
            digit_blank_c = (disp_q.whole_tens == 4'd0);
            dp_c          = ~disp_q.sign;
         end
         default: digit_bcd_c = disp_q.frac_ones;
      endcase
   end

   seven_segment_digit_decoder u_decoder (
      .bcd        (digit_bcd_c),
      .blank      (digit_blank_c),
      .segments_c (segments_c)
   );

   assign disp.anode   = disp.blank ? 4'b1111 : ~(4'b0001 << digit_idx);
   assign disp.cathode = segments_c;
   assign disp.dp      = dp_c;
   assign disp.busy    = busy_q;
   assign disp.clamped = disp_q.clamped;

endmodule
